// File: rtl/alt_aeuex_reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// alt_aeuex_reset_seq_pkg
// Shared types and helpers for the multi-stage reset sequencer.
//   state_e  : sequencer FSM states
//   RETRY_W  : width of the consecutive-timeout counter
//   clog2max : counter width able to hold the largest of three cycle counts
// -----------------------------------------------------------------------------
package alt_aeuex_reset_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ACK = 3'd1,
        SETTLE   = 3'd2,
        HOLDOFF  = 3'd3,
        RUN      = 3'd4,
        LOCKOUT  = 3'd5
    } state_e;

    localparam int RETRY_W = 4;

    // Width of a counter that must reach (max(a,b,c) - 1); never below 1 bit.
    function automatic int clog2max(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/alt_aeuex_reset_seq_cnt.sv
// -----------------------------------------------------------------------------
// alt_aeuex_reset_seq_cnt
// Clear/enable up-counter with a terminal-count flag. One instance serves the
// SETTLE, HOLDOFF and acknowledge-timeout intervals since only one of them is
// ever active at a time; the caller selects the terminal value per state.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to zero (wins over en_i)
//   en_i       : count enable
//   term_i     : terminal value compared against the current count
//   tc_o       : high while the count equals term_i
// -----------------------------------------------------------------------------
module alt_aeuex_reset_seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/alt_aeuex_reset_seq.sv
// -----------------------------------------------------------------------------
// alt_aeuex_reset_seq
// Releases a chain of downstream resets one stage at a time. Each released
// stage must acknowledge on stage_ready before the next is released; loss of
// acknowledge or an acknowledge timeout re-sequences from the failing stage,
// and repeated timeouts lock the sequencer out until ready_in drops.
// Ports:
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   ready_in    : sequence enable; low returns every stage to reset
//   stage_ready : per-stage acknowledge/lock
//   stage_rst_n : per-stage active-low reset (registered)
//   all_ready   : all stages released and settled (registered)
//   retry_cnt   : consecutive acknowledge-timeout count
//   lockout     : sticky retry-limit flag
// -----------------------------------------------------------------------------
module alt_aeuex_reset_seq
    import alt_aeuex_reset_seq_pkg::*;
#(
    parameter int STAGES         = 3,
    parameter int SETTLE_CYCLES  = 16,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ready_in,
    input  logic [STAGES-1:0]  stage_ready,
    output logic [STAGES-1:0]  stage_rst_n,
    output logic               all_ready,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lockout
);

    localparam int CNT_W = clog2max(SETTLE_CYCLES, HOLDOFF_CYCLES, TIMEOUT_CYCLES);
    localparam int K_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CNT_W-1:0]   SETTLE_TC  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HOLDOFF_TC = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [K_W-1:0]     LAST_K     = K_W'(STAGES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    state_e               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [STAGES-1:0]    rst_q, rst_d;
    logic                 all_q, all_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [RETRY_W-1:0]   retry_inc;
    logic                 lock_q, lock_d;

    logic                 cnt_clr, cnt_en, cnt_tc;
    logic [CNT_W-1:0]     cnt_term;
    logic                 loss_found;
    logic [K_W-1:0]       loss_j;

    // The same counter times all three intervals; pick its terminal by state.
    always_comb begin
        case (state_q)
            SETTLE:  cnt_term = SETTLE_TC;
            HOLDOFF: cnt_term = HOLDOFF_TC;
            default: cnt_term = TIMEOUT_TC;
        endcase
    end

    alt_aeuex_reset_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .tc_o   (cnt_tc)
    );

    // Lowest released stage that dropped its acknowledge. In WAIT_ACK the
    // current stage has not acknowledged yet, so only earlier stages count.
    // HOLDOFF, IDLE and LOCKOUT never report a loss.
    always_comb begin
        loss_found = 1'b0;
        loss_j     = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            if (!stage_ready[j] &&
                ((state_q == WAIT_ACK && j < int'(k_q)) ||
                 ((state_q == SETTLE || state_q == RUN) && j <= int'(k_q)))) begin
                loss_found = 1'b1;
                loss_j     = K_W'(j);
            end
        end
    end

    assign retry_inc = retry_q + RETRY_W'(1);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rst_d   = rst_q;
        all_d   = all_q;
        retry_d = retry_q;
        lock_d  = lock_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        if (!ready_in) begin
            state_d = IDLE;
            k_d     = '0;
            rst_d   = '0;
            all_d   = 1'b0;
            retry_d = '0;
            lock_d  = 1'b0;
            cnt_clr = 1'b1;
        end else if (loss_found) begin
            // A loss is not a timeout: retry_cnt is left alone.
            for (int i = 0; i < STAGES; i++) begin
                if (i >= int'(loss_j)) rst_d[i] = 1'b0;
            end
            all_d   = 1'b0;
            k_d     = loss_j;
            state_d = HOLDOFF;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    rst_d[0] = 1'b1;
                    state_d  = WAIT_ACK;
                    cnt_clr  = 1'b1;
                end
                WAIT_ACK: begin
                    // Acknowledge is tested first so it wins a same-edge timeout.
                    if (stage_ready[k_q]) begin
                        state_d = SETTLE;
                        cnt_clr = 1'b1;
                    end else if (cnt_tc) begin
                        for (int i = 0; i < STAGES; i++) begin
                            if (i >= int'(k_q)) rst_d[i] = 1'b0;
                        end
                        retry_d = retry_inc;
                        if (retry_inc == RETRY_LIM) begin
                            state_d = LOCKOUT;
                            lock_d  = 1'b1;
                        end else begin
                            state_d = HOLDOFF;
                        end
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_tc) begin
                        if (k_q == LAST_K) begin
                            state_d = RUN;
                            all_d   = 1'b1;
                            retry_d = '0;
                        end else begin
                            for (int i = 0; i < STAGES; i++) begin
                                if (i == int'(k_q) + 1) rst_d[i] = 1'b1;
                            end
                            k_d     = k_q + K_W'(1);
                            state_d = WAIT_ACK;
                        end
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (cnt_tc) begin
                        rst_d[k_q] = 1'b1;
                        state_d    = WAIT_ACK;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                RUN, LOCKOUT: begin
                    cnt_clr = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            rst_q   <= '0;
            all_q   <= 1'b0;
            retry_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rst_q   <= rst_d;
            all_q   <= all_d;
            retry_q <= retry_d;
            lock_q  <= lock_d;
        end
    end

    assign stage_rst_n = rst_q;
    assign all_ready   = all_q;
    assign retry_cnt   = retry_q;
    assign lockout     = lock_q;

endmodule

// File: tb/tb_alt_aeuex_reset_seq.sv
module tb_alt_aeuex_reset_seq;

    localparam int STAGES  = 3;
    localparam int SETTLE  = 4;
    localparam int HOLDOFF = 8;
    localparam int TIMEOUT = 16;
    localparam int MAXR    = 3;

    logic              clk;
    logic              rst_n;
    logic              ready_in;
    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] stage_rst_n;
    logic              all_ready;
    logic [3:0]        retry_cnt;
    logic              lockout;

    int n_chk = 0;
    int n_err = 0;

    alt_aeuex_reset_seq #(
        .STAGES         (STAGES),
        .SETTLE_CYCLES  (SETTLE),
        .HOLDOFF_CYCLES (HOLDOFF),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRY      (MAXR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready_in    (ready_in),
        .stage_ready (stage_ready),
        .stage_rst_n (stage_rst_n),
        .all_ready   (all_ready),
        .retry_cnt   (retry_cnt),
        .lockout     (lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count edges until stage_rst_n reaches exp; the count must equal lat.
    task automatic wait_rst(input string tag, input logic [2:0] exp, input int lat);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (stage_rst_n !== exp && n < lat + 20);
        check_val(tag, n, lat);
    endtask

    task automatic restart(input string tag);
        ready_in    = 1'b0;
        stage_ready = '0;
        step(1);
        ready_in = 1'b1;
        step(1);
        check_val({tag, "_rel0"}, stage_rst_n, 3'b001);
    endtask

    // From stage 0 just released: acknowledge each stage one edge after its
    // release and walk all the way to all_ready.
    task automatic bring_up(input string tag);
        step(1);
        stage_ready[0] = 1'b1;
        wait_rst({tag, "_lat1"}, 3'b011, 1 + SETTLE);
        step(1);
        stage_ready[1] = 1'b1;
        wait_rst({tag, "_lat2"}, 3'b111, 1 + SETTLE);
        step(1);
        stage_ready[2] = 1'b1;
        step(SETTLE);
        check_val({tag, "_allrdy_early"}, all_ready, 1'b0);
        step(1);
        check_val({tag, "_allrdy"}, all_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        ready_in    = 1'b0;
        stage_ready = '0;
        #3;
        check_val("reset_rst_n", stage_rst_n, 3'b000);
        check_val("reset_all", all_ready, 1'b0);
        check_val("reset_retry", retry_cnt, 4'd0);
        check_val("reset_lock", lockout, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check_val("idle_hold", stage_rst_n, 3'b000);

        // Happy path
        restart("s1");
        bring_up("s1");
        check_val("s1_retry", retry_cnt, 4'd0);
        check_val("s1_rst", stage_rst_n, 3'b111);

        // Timeout on stage 1, retry, then recover
        ready_in = 1'b0;
        step(1);
        check_val("s2_low_rst", stage_rst_n, 3'b000);
        check_val("s2_low_all", all_ready, 1'b0);
        restart("s2");
        step(1);
        stage_ready[0] = 1'b1;
        wait_rst("s2_lat1", 3'b011, 1 + SETTLE);
        wait_rst("s2_timeout", 3'b001, TIMEOUT);
        check_val("s2_retry1", retry_cnt, 4'd1);
        wait_rst("s2_rerel", 3'b011, HOLDOFF);
        step(1);
        stage_ready[1] = 1'b1;
        wait_rst("s2_lat2", 3'b111, 1 + SETTLE);
        check_val("s2_retry_hold", retry_cnt, 4'd1);
        step(1);
        stage_ready[2] = 1'b1;
        step(1 + SETTLE);
        check_val("s2_allrdy", all_ready, 1'b1);
        check_val("s2_retry0", retry_cnt, 4'd0);

        // Lockout: stage 2 never acknowledges
        restart("s3");
        step(1);
        stage_ready[0] = 1'b1;
        wait_rst("s3_lat1", 3'b011, 1 + SETTLE);
        step(1);
        stage_ready[1] = 1'b1;
        wait_rst("s3_lat2", 3'b111, 1 + SETTLE);
        wait_rst("s3_to1", 3'b011, TIMEOUT);
        check_val("s3_retry1", retry_cnt, 4'd1);
        wait_rst("s3_rr1", 3'b111, HOLDOFF);
        wait_rst("s3_to2", 3'b011, TIMEOUT);
        check_val("s3_retry2", retry_cnt, 4'd2);
        check_val("s3_nolock", lockout, 1'b0);
        wait_rst("s3_rr2", 3'b111, HOLDOFF);
        wait_rst("s3_to3", 3'b011, TIMEOUT);
        check_val("s3_retry3", retry_cnt, 4'd3);
        check_val("s3_lock", lockout, 1'b1);
        step(30);
        check_val("s3_lock_hold", stage_rst_n, 3'b011);
        stage_ready[0] = 1'b0;
        step(3);
        check_val("s3_lock_noloss", stage_rst_n, 3'b011);
        check_val("s3_lock_sticky", lockout, 1'b1);
        ready_in    = 1'b0;
        stage_ready = '0;
        step(1);
        check_val("s3_clr_rst", stage_rst_n, 3'b000);
        check_val("s3_clr_lock", lockout, 1'b0);
        check_val("s3_clr_retry", retry_cnt, 4'd0);
        check_val("s3_clr_all", all_ready, 1'b0);
        restart("s3b");
        bring_up("s3b");

        // Loss in RUN: stage 1 drops for one cycle
        stage_ready[1] = 1'b0;
        step(1);
        stage_ready[1] = 1'b1;
        check_val("s4_loss_rst", stage_rst_n, 3'b001);
        check_val("s4_loss_all", all_ready, 1'b0);
        wait_rst("s4_rerel", 3'b011, HOLDOFF);
        check_val("s4_retry", retry_cnt, 4'd0);
        wait_rst("s4_lat2", 3'b111, 1 + SETTLE);
        step(SETTLE);
        check_val("s4_allrdy_early", all_ready, 1'b0);
        step(1);
        check_val("s4_allrdy", all_ready, 1'b1);

        // Same-edge acknowledge and timeout, then ready_in low in SETTLE
        restart("s5");
        step(1);
        stage_ready[0] = 1'b1;
        wait_rst("s5_lat1", 3'b011, 1 + SETTLE);
        step(TIMEOUT - 1);
        stage_ready[1] = 1'b1;
        step(1);
        check_val("s5_ack_wins", stage_rst_n, 3'b011);
        check_val("s5_no_retry", retry_cnt, 4'd0);
        step(SETTLE - 1);
        check_val("s5_settling", stage_rst_n, 3'b011);
        ready_in = 1'b0;
        step(1);
        check_val("s5_low_rst", stage_rst_n, 3'b000);

        // Async rst_n during HOLDOFF
        restart("s6");
        step(1);
        stage_ready[0] = 1'b1;
        wait_rst("s6_lat1", 3'b011, 1 + SETTLE);
        wait_rst("s6_timeout", 3'b001, TIMEOUT);
        check_val("s6_retry1", retry_cnt, 4'd1);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("s6_async_rst", stage_rst_n, 3'b000);
        check_val("s6_async_retry", retry_cnt, 4'd0);
        stage_ready = '0;
        #1;
        rst_n = 1'b1;
        step(1);
        check_val("s6_restart", stage_rst_n, 3'b001);
        bring_up("s6");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
